// File: rtl/cad_serial_result_rx.sv
// Receive side of the CAD serial result link: assembles LSB-first words from a
// 1-bit stream, buffers them in a small FIFO and flags framing/overflow errors.
module cad_serial_result_rx #(
  parameter int unsigned WORD_W     = 20,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              out_valid,
  input  logic              out_value,
  input  logic [LEN_W-1:0]  frame_len,
  output logic [WORD_W-1:0] word_data,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LW1   = LEN_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BIT_W-1:0]  r_bit_cnt;
  logic [LEN_W-1:0]  r_word_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [WORD_W-2:0] r_shift;

  logic [WORD_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [WORD_W-1:0] r_word_data;
  logic              r_word_last;
  logic              r_word_valid;
  logic              r_err_valid;
  logic [1:0]        r_err_code;

  logic              w_bit_sample;
  logic              w_word_done;
  logic              w_excess;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_last;
  logic [WORD_W-1:0] w_word;
  logic              w_err_set;
  logic [1:0]        w_err_code;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [PTR_W-1:0]  w_rd_nxt;

  assign w_word_done = (r_state == ST_RECV) & out_valid &
                       (r_bit_cnt == BIT_W'(WORD_W - 1));
  assign w_word      = {out_value, r_shift};
  assign w_excess    = (r_word_cnt >= r_len);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop       = r_word_valid & word_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push      = w_word_done & ~w_excess & (~w_full | w_pop);
  assign w_last      = (LW1'(r_word_cnt) + LW1'(1)) == LW1'(r_len);
  assign w_rd_nxt    = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bit_sample = 1'b0;
    w_err_set    = 1'b0;
    w_err_code   = 2'd0;
    case (r_state)
      ST_IDLE: begin
        if (out_valid) begin
          w_state_nxt  = ST_RECV;
          w_bit_sample = 1'b1;
        end
      end
      ST_RECV: begin
        if (out_valid) begin
          w_bit_sample = 1'b1;
          if (w_word_done && !w_push) begin
            w_err_set  = 1'b1;
            w_err_code = 2'd3;
          end
        end else begin
          w_state_nxt = ST_IDLE;
          if (r_bit_cnt != '0) begin
            w_err_set  = 1'b1;
            w_err_code = 2'd1;
          end else if (r_word_cnt < r_len) begin
            w_err_set  = 1'b1;
            w_err_code = 2'd2;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Deserializer; word_cnt saturates so an endless frame stays "excess".
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_shift    <= '0;
    end else if (w_bit_sample) begin
      if (r_state == ST_IDLE) begin
        r_len      <= frame_len;
        r_shift    <= (WORD_W-1)'(out_value);
        r_bit_cnt  <= BIT_W'(1);
        r_word_cnt <= '0;
      end else if (w_word_done) begin
        r_bit_cnt <= '0;
        if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + LEN_W'(1);
      end else begin
        r_shift[r_bit_cnt] <= out_value;
        r_bit_cnt          <= r_bit_cnt + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_word;
      r_mem_last[r_wr_ptr] <= w_last;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Head register only moves on a pop or on a push into an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_word_data  <= '0;
      r_word_last  <= 1'b0;
      r_word_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_count      <= w_count_nxt;
      r_word_valid <= (w_count_nxt != '0);
      if (w_pop) begin
        if (r_count > CNT_W'(1)) begin
          r_word_data <= r_mem_data[w_rd_nxt];
          r_word_last <= r_mem_last[w_rd_nxt];
        end else if (w_push) begin
          r_word_data <= w_word;
          r_word_last <= w_last;
        end
      end else if (w_push && (r_count == '0)) begin
        r_word_data <= w_word;
        r_word_last <= w_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_err_valid <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_err_valid <= w_err_set;
      if (w_err_set) r_err_code <= w_err_code;
    end
  end

  assign word_data  = r_word_data;
  assign word_last  = r_word_last;
  assign word_valid = r_word_valid;
  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;
  assign busy       = (r_state == ST_RECV);

endmodule

// File: doc/cad_serial_result_rx.md
Name: cad_serial_result_rx

Overview:
- Receiving end of the CAD serial result interface.
- Samples the 1-bit out_value stream while out_valid is high and assembles LSB-first WORD_W-bit results into parallel words.
- Buffers the words in a small FIFO and presents them through a valid/ready port to the checker or downstream logic.
- Detects framing errors: truncated word, short or long frame, FIFO overflow.

Parameters:
- WORD_W, 20, bits per result word; the serial stream is LSB first.
- FIFO_DEPTH, 4, number of buffered words (power of two, at least 2).
- LEN_W, 10, width of the frame_len word-count input.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-high: asserted when 1 and sampled on the clk edge.
- out_valid  in  1  serial stream valid; high continuously for a whole frame.
- out_value  in  1  serial data bit, sampled only when out_valid=1.
- frame_len  in  LEN_W  expected words in the frame; latched on the first valid bit of a frame.
- word_data  out  WORD_W  head-of-FIFO word.
- word_last  out  1  head word is the frame_len-th word of its frame.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word when word_valid & word_ready.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  1 = truncated word, 2 = short frame, 3 = overflow/excess; holds its last value between pulses.
- busy  out  1  high while a frame is in progress (state RECV).

Behaviour:
- Reset (rst_n=1 at an edge):
  - state IDLE; bit counter, word counter and shift register cleared; FIFO emptied.
  - word_valid=0, word_data=0, word_last=0, err_valid=0, err_code=0, busy=0.
  - Reset mid-frame discards every partial and buffered word. The rest of the frame is then received as a new frame when out_valid=1 is next seen.
- State IDLE:
  - out_valid=1 → latch frame_len, shift in bit 0, bit counter=1, go to RECV.
  - out_valid=0 → stay in IDLE.
- State RECV with out_valid=1:
  - Shift out_value into bit position bit_cnt; bit_cnt increments.
  - On bit WORD_W-1 the word is complete and bit_cnt wraps to 0.
  - word_cnt increments on each completed word.
  - The completed word is pushed with last = (word_cnt+1 == latched frame_len).
- State RECV with out_valid=0 (end of frame):
  - bit_cnt != 0 → err_code=1; the partial word is dropped.
  - Otherwise, word_cnt < frame_len → err_code=2.
  - Go to IDLE the same edge.
  - Priority when several apply: code 1 over code 2.
- Excess and overflow:
  - A word that completes when word_cnt already equals frame_len is dropped; err_code=3 pulses.
  - frame_len=0 makes every word excess.
  - A word that completes while the FIFO is full and no pop happens that cycle is dropped; err_code=3 pulses.
  - The stream cannot be back-pressured, so word_cnt still increments on a dropped word.
- Latency:
  - Bit k of a word is sampled at edge k, for k = 0..WORD_W-1.
  - If the FIFO was empty, word_valid=1 with that word on word_data after edge WORD_W-1, i.e. in the next cycle.
  - Back-to-back frames: out_valid low for 1 cycle is sufficient between frames.
- FIFO:
  - Push and pop in the same cycle are both performed, even when full or empty-then-push.
  - Read and write pointers wrap modulo FIFO_DEPTH; occupancy counter is 0..FIFO_DEPTH.
  - word_data and word_last change only on a pop or on a push into an empty FIFO.
  - word_data is stable while word_valid=1 and word_ready=0.
- Errors: err_valid is a single-cycle pulse. Simultaneous end-of-frame and overflow cannot occur, because end-of-frame has out_valid=0.

Test Plan:
- Nominal frame:
  - Stimulus: frame_len=2, word_ready=1, 40 bits of 0x12345 then 0xABCDE, LSB first.
  - Response: word_valid after edge 19 with 0x12345, last=0; after edge 39 with 0xABCDE, last=1; busy drops after out_valid falls; no err_valid.
- Backpressure and overflow:
  - Stimulus: FIFO_DEPTH=4, word_ready=0, frame_len=6, words 1..6.
  - Response: FIFO holds 1,2,3,4; words 5 and 6 each give an err_valid pulse with err_code=3.
  - Then word_ready=1 → words 1,2,3,4 pop in order, and word_valid falls after the 4th pop.
- Truncated frame:
  - Stimulus: frame_len=1, out_valid high for 27 bits.
  - Response: word 1 delivered; one err_valid pulse with err_code=1 on the falling edge of out_valid; partial word never appears.
- Short and excess frames:
  - Stimulus: frame_len=3 with 2 words sent.
  - Response: err_code=2 at end of frame.
  - Stimulus: frame_len=1 with 2 words sent.
  - Response: second word dropped with err_code=3; first word carries last=1.
- Reset mid-frame and back-to-back frames:
  - Stimulus: rst_n=1 for one cycle after bit 10 of a frame, with FIFO holding 2 words.
  - Response: word_valid=0 next cycle and no err_valid.
  - Stimulus: two frames separated by one idle cycle.
  - Response: both frames' words delivered in order, with frame_len re-latched for each frame.
